// File: rtl/recebe_movimentos_buf.sv
// Serial move receiver: requests a sequence over 8N1 UART, decodes and buffers ASCII moves, then replays them.
// Replay uses valid/ready; a move is held on movimento until movimento_pronto accepts it, one per cycle at best.
module recebe_movimentos_buf #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         DEPTH        = 32,
  parameter int         MOV_W        = 3,
  parameter int         N_MOV        = 6,
  parameter logic [7:0] REQ_BYTE     = 8'h52,
  parameter logic [7:0] END_BYTE     = 8'h23,
  parameter int         TIMEOUT      = 50_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic                       entrada_serial,
  input  logic                       movimento_pronto,
  output logic                       saida_serial,
  output logic [MOV_W-1:0]           movimento,
  output logic                       movimento_valido,
  output logic [$clog2(DEPTH+1)-1:0] num_movimentos,
  output logic                       ocupado,
  output logic                       pronto,
  output logic                       erro,
  output logic [3:0]                 db_estado
);

  localparam int NW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    ENVIA_REQ   = 4'd1,
    ESPERA_BYTE = 4'd2,
    ARMAZENA    = 4'd3,
    EXECUTA     = 4'd4,
    FIM         = 4'd5,
    ERRO        = 4'd15
  } estado_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_estado_t;

  estado_t            estado;
  estado_t            prox;
  rx_estado_t         rx_estado;

  logic               rx_s1;
  logic               rx_s2;
  logic               rx_prev;
  logic [CW-1:0]      rx_cnt;
  logic [2:0]         rx_idx;
  logic [7:0]         rx_shift;
  logic [7:0]         rx_byte;
  logic               rx_vld;
  logic               rx_ferr;

  logic               tx_line;
  logic [CW-1:0]      tx_cnt;
  logic [3:0]         tx_idx;

  logic [MOV_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr;
  logic [NW-1:0]      rd;
  logic [TW-1:0]      tmo;

  logic               inicia;
  logic               fim_tx;
  logic               eh_mov;
  logic               tmo_fim;
  logic               ultimo;
  logic [MOV_W-1:0]   mov_dec;

  // RX sampler: free-running, frames start on a falling edge of the synchronised line
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_estado <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_vld    <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_s1   <= entrada_serial;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_estado)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_estado <= RX_START;
            rx_cnt    <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_estado <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_idx == 3'd7) begin
              rx_estado <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt    <= '0;
            rx_estado <= RX_IDLE;
            if (rx_s2) begin
              rx_vld  <= 1'b1;
              rx_byte <= rx_shift;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_estado <= RX_IDLE;
      endcase
    end
  end

  assign inicia  = iniciar && (estado == INICIAL || estado == FIM || estado == ERRO);
  assign fim_tx  = (estado == ENVIA_REQ) && (tx_idx == 4'd9) && (tx_cnt == CW'(CLKS_PER_BIT - 1));
  assign eh_mov  = (rx_byte >= 8'h30) && (rx_byte < 8'(48 + N_MOV));
  assign tmo_fim = (tmo == TW'(TIMEOUT - 1));
  assign ultimo  = ((rd + NW'(1)) == num_movimentos);
  assign mov_dec = MOV_W'(rx_byte - 8'h30);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL, FIM, ERRO: begin
        if (iniciar) prox = ENVIA_REQ;
      end
      ENVIA_REQ: begin
        if (fim_tx) prox = ESPERA_BYTE;
      end
      ESPERA_BYTE: begin
        if (rx_ferr) begin
          prox = ERRO;
        end else if (rx_vld) begin
          if (rx_byte == END_BYTE) begin
            prox = (num_movimentos == '0) ? FIM : EXECUTA;
          end else if (eh_mov && (num_movimentos < NW'(DEPTH))) begin
            prox = ARMAZENA;
          end else begin
            prox = ERRO;
          end
        end else if (tmo_fim) begin
          prox = ERRO;
        end
      end
      ARMAZENA: prox = ESPERA_BYTE;
      EXECUTA: begin
        if (movimento_pronto && ultimo) prox = FIM;
      end
      default: prox = INICIAL;
    endcase
  end

  // Request transmitter: the start bit is loaded on the same edge that enters ENVIA_REQ
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_line <= 1'b1;
      tx_cnt  <= '0;
      tx_idx  <= '0;
    end else if (inicia) begin
      tx_line <= 1'b0;
      tx_cnt  <= '0;
      tx_idx  <= '0;
    end else if (estado == ENVIA_REQ) begin
      if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
        tx_cnt  <= '0;
        tx_idx  <= tx_idx + 4'd1;
        tx_line <= (tx_idx < 4'd8) ? REQ_BYTE[tx_idx[2:0]] : 1'b1;
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr             <= '0;
      rd             <= '0;
      num_movimentos <= '0;
      tmo            <= '0;
      pronto         <= 1'b0;
      erro           <= 1'b0;
    end else begin
      if (inicia) begin
        wr             <= '0;
        rd             <= '0;
        num_movimentos <= '0;
        pronto         <= 1'b0;
        erro           <= 1'b0;
      end
      if (estado == ARMAZENA) begin
        wr             <= wr + AW'(1);
        num_movimentos <= num_movimentos + NW'(1);
      end
      if (estado == EXECUTA && movimento_pronto) begin
        rd <= rd + NW'(1);
      end
      if (prox == FIM && estado != FIM) pronto <= 1'b1;
      if (prox == ERRO && estado != ERRO) erro <= 1'b1;
      // Idle time is measured only while waiting for a byte; every other state restarts it
      if (estado == ESPERA_BYTE) begin
        tmo <= tmo + TW'(1);
      end else begin
        tmo <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (estado == ARMAZENA) begin
      mem[wr] <= mov_dec;
    end
  end

  assign saida_serial     = tx_line;
  assign movimento_valido = (estado == EXECUTA);
  assign movimento        = movimento_valido ? mem[rd[AW-1:0]] : '0;
  assign ocupado          = !(estado == INICIAL || estado == FIM || estado == ERRO);
  assign db_estado        = estado;

endmodule

// File: tb/tb_recebe_movimentos_buf.sv
// Directed and random transactions against a queue-based model of the receive/validate/replay rules.
module tb_recebe_movimentos_buf;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 2000;
  localparam int MOV_W = 3;
  localparam int N_MOV = 6;
  localparam int NW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             iniciar;
  logic             entrada_serial;
  logic             movimento_pronto;
  logic             saida_serial;
  logic [MOV_W-1:0] movimento;
  logic             movimento_valido;
  logic [NW-1:0]    num_movimentos;
  logic             ocupado;
  logic             pronto;
  logic             erro;
  logic [3:0]       db_estado;

  int errors = 0;
  int checks = 0;

  logic [MOV_W-1:0] hs_q[$];
  int               vld_cycles;
  logic             hold_pending = 1'b0;
  logic [MOV_W-1:0] held_mov;

  recebe_movimentos_buf #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .MOV_W       (MOV_W),
    .N_MOV       (N_MOV),
    .REQ_BYTE    (8'h52),
    .END_BYTE    (8'h23),
    .TIMEOUT     (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .entrada_serial  (entrada_serial),
    .movimento_pronto(movimento_pronto),
    .saida_serial    (saida_serial),
    .movimento       (movimento),
    .movimento_valido(movimento_valido),
    .num_movimentos  (num_movimentos),
    .ocupado         (ocupado),
    .pronto          (pronto),
    .erro            (erro),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Handshake recorder; a presented move must not change until it is accepted
  always @(negedge clock) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else if (movimento_valido) begin
      vld_cycles++;
      if (hold_pending) check("hold_stable", movimento, held_mov);
      if (movimento_pronto) begin
        hs_q.push_back(movimento);
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held_mov     = movimento;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_tx"},     saida_serial,     1);
    check({tag, "_mov"},    movimento,        0);
    check({tag, "_vld"},    movimento_valido, 0);
    check({tag, "_num"},    num_movimentos,   0);
    check({tag, "_ocup"},   ocupado,          0);
    check({tag, "_pronto"}, pronto,           0);
    check({tag, "_erro"},   erro,             0);
    check({tag, "_est"},    db_estado,        0);
  endtask

  // Pulses iniciar (held one extra cycle, which must be ignored) and decodes the request frame
  task automatic start_txn(input string tag);
    logic [9:0] frame;
    logic [9:0] want;
    want    = {1'b1, 8'h52, 1'b0};
    iniciar = 1'b1;
    tick;
    check({tag, "_req_est"}, db_estado, 1);
    check({tag, "_req_start"}, saida_serial, 0);
    check({tag, "_req_clr"}, {pronto, erro}, 0);
    tick;
    iniciar = 1'b0;
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? CPB / 2 - 1 : CPB) tick;
      frame[k] = saida_serial;
    end
    check({tag, "_req_frame"}, frame, want);
    repeat (CPB / 2 - 1) tick;
    check({tag, "_req_last"}, db_estado, 1);
    tick;
    check({tag, "_req_wait"}, db_estado, 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    entrada_serial = 1'b0;
    repeat (CPB) tick;
    for (int k = 0; k < 8; k++) begin
      entrada_serial = b[k];
      repeat (CPB) tick;
    end
    entrada_serial = stop_bit;
    repeat (CPB) tick;
    entrada_serial = 1'b1;
    if (!stop_bit) repeat (CPB) tick;
  endtask

  // seq entries: 0..255 are bytes, 256 is a frame with a bad stop bit
  task automatic run_seq(input int seq[$], input int mode, input string tag);
    logic [MOV_W-1:0] exp_q[$];
    logic             exp_err;
    logic             done;
    logic [31:0]      v;
    int               n;
    exp_err = 1'b0;
    done    = 1'b0;
    foreach (seq[i]) begin
      if (!done && !exp_err) begin
        if (seq[i] > 255) exp_err = 1'b1;
        else if (seq[i] == 35) done = 1'b1;
        else if (seq[i] >= 48 && seq[i] < 48 + N_MOV && exp_q.size() < DEPTH)
          exp_q.push_back(MOV_W'(seq[i] - 48));
        else exp_err = 1'b1;
      end
    end
    if (!done) exp_err = 1'b1;

    hs_q.delete();
    vld_cycles       = 0;
    movimento_pronto = (mode == 0);
    start_txn(tag);
    foreach (seq[i]) begin
      v = seq[i];
      send_byte(v[7:0], v < 256);
    end
    n = 0;
    while (!(pronto || erro) && n < 3000) begin
      case (mode)
        0:       movimento_pronto = 1'b1;
        1:       movimento_pronto = ((n / 3) % 2) == 0;
        default: movimento_pronto = 1'($urandom_range(0, 1));
      endcase
      tick;
      n++;
    end
    movimento_pronto = 1'b0;
    tick;
    check({tag, "_erro"},   erro,   exp_err);
    check({tag, "_pronto"}, pronto, !exp_err);
    check({tag, "_est"},    db_estado, exp_err ? 15 : 5);
    check({tag, "_ocup"},   ocupado, 0);
    check({tag, "_vld_end"}, {movimento_valido, movimento}, 0);
    check({tag, "_nhs"},    hs_q.size(), exp_err ? 0 : exp_q.size());
    if (!exp_err) begin
      check({tag, "_num"}, num_movimentos, exp_q.size());
      if (hs_q.size() == exp_q.size())
        foreach (exp_q[i]) check($sformatf("%s_mov%0d", tag, i), hs_q[i], exp_q[i]);
      if (mode == 0) check({tag, "_vld_cycles"}, vld_cycles, exp_q.size());
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int n;
    int len;
    reset            = 1'b1;
    iniciar          = 1'b0;
    entrada_serial   = 1'b1;
    movimento_pronto = 1'b0;
    repeat (3) tick;
    check_reset("rst");
    reset = 1'b0;
    repeat (4) tick;
    check_reset("idle");

    seq = {50, 48, 53, 35};
    run_seq(seq, 0, "norm");
    run_seq(seq, 1, "bp");
    seq = {35};
    run_seq(seq, 0, "empty");
    seq = {55, 35};
    run_seq(seq, 0, "bad7");
    seq = {50, 256, 35};
    run_seq(seq, 0, "frame");

    // Overflow: the fifth valid move must be rejected
    start_txn("ovf");
    repeat (4) send_byte(8'h31, 1'b1);
    repeat (4) tick;
    check("ovf_est4", db_estado, 2);
    check("ovf_num4", num_movimentos, 4);
    send_byte(8'h31, 1'b1);
    repeat (4) tick;
    check("ovf_erro", erro, 1);
    check("ovf_est", db_estado, 15);
    check("ovf_pronto", pronto, 0);

    // Timeout counted from the end of the request stop bit
    start_txn("tmo");
    n = 0;
    while (!erro && n < 3000) begin
      tick;
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_est", db_estado, 15);

    // Reset in the middle of a received frame, then a clean transaction
    start_txn("rec");
    send_byte(8'h32, 1'b1);
    entrada_serial = 1'b0;
    repeat (3 * CPB) tick;
    reset = 1'b1;
    tick;
    check_reset("mid_rst");
    reset          = 1'b0;
    entrada_serial = 1'b1;
    repeat (4) tick;
    seq = {51, 35};
    run_seq(seq, 0, "recov");

    for (int r = 0; r < 6; r++) begin
      seq.delete();
      len = $urandom_range(0, DEPTH);
      for (int i = 0; i < len; i++) seq.push_back(48 + $urandom_range(0, N_MOV - 1));
      if ($urandom_range(0, 3) == 0) seq.insert($urandom_range(0, len), $urandom_range(0, 255));
      seq.push_back(35);
      run_seq(seq, 2, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
